// File: rtl/uart_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_wr_arbiter
// Description : Packet-locked round-robin arbiter for the UART TX FIFO write
//               port. Define UART_ARB_GRANT_TIMEOUT_EN for the grant timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_wr_en_o,
   output logic [DATA_W-1:0]         fifo_wr_data_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o,
   output logic                      timeout_flag_o
);

   localparam logic [IDX_W:0] c_num_req = (IDX_W+1)'(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || (2**IDX_W) < NUM_REQ || TIMEOUT < 2) begin : g_param_check
      $error("uart_fifo_wr_arbiter: illegal parameter combination");
   end

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   gidx_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic               busy_q;

   logic               w_valid_g;
   logic               w_last_g;
   logic               w_xfer;
   logic               w_expire;
   logic [DATA_W-1:0]  w_data_g;
   logic               w_pick_found;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [NUM_REQ-1:0] w_pick_oh;
   logic [NUM_REQ-1:0] w_vshift;
   logic [IDX_W:0]     w_cand;
   logic [IDX_W:0]     w_inc;
   logic [IDX_W-1:0]   w_next_ptr;

   // grant_q is zero outside GRANT, so every granted-side term is zero in IDLE.
   always_comb begin
      w_valid_g = |(req_valid_i & grant_q);
      w_last_g  = |(req_last_i & grant_q);
      w_data_g  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            w_data_g = w_data_g | req_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_xfer = w_valid_g & ~fifo_full_i;

   // Walk downward so the closest index at or above rr_ptr is the last to win.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      w_vshift     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (w_cand >= c_num_req) begin
            w_cand = w_cand - c_num_req;
         end
         w_vshift = req_valid_i >> w_cand;
         if (w_vshift[0]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand[IDX_W-1:0];
         end
      end
   end

   assign w_pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
   assign w_inc      = {1'b0, gidx_q} + (IDX_W+1)'(1);
   assign w_next_ptr = (w_inc == c_num_req) ? '0 : w_inc[IDX_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_pick_found) begin
                  state_q <= S_GRANT;
                  grant_q <= w_pick_oh;
                  gidx_q  <= w_pick_idx;
                  busy_q  <= 1'b1;
               end
            end
            S_GRANT: begin
               if ((w_xfer && w_last_g) || w_expire) begin
                  state_q  <= S_IDLE;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
                  rr_ptr_q <= w_next_ptr;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef UART_ARB_GRANT_TIMEOUT_EN
   localparam int               CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] idle_cnt_q;
   logic [CNT_W-1:0] idle_cnt_d;
   logic             timeout_q;

   // Only cycles with the owner silent count; a full-FIFO stall does not.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      w_expire   = 1'b0;
      if (state_q != S_GRANT || w_xfer) begin
         idle_cnt_d = '0;
      end else if (!w_valid_g) begin
         if (idle_cnt_q == c_tmo_last) begin
            w_expire   = 1'b1;
            idle_cnt_d = '0;
         end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= w_expire;
      end
   end

   assign timeout_flag_o = timeout_q;
`else
   assign w_expire       = 1'b0;
   assign timeout_flag_o = 1'b0;
`endif

   assign req_ready_o    = grant_q & {NUM_REQ{~fifo_full_i}};
   assign fifo_wr_en_o   = w_xfer;
   assign fifo_wr_data_o = w_data_g;
   assign grant_o        = grant_q;
   assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_wr_arbiter
// Description : Self-checking bench for uart_fifo_wr_arbiter against a
//               behavioural arbiter/FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DEPTH = 15;
   localparam int TMO   = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           fifo_full;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_wr_data;
   logic [N-1:0]   grant;
   logic           busy;
   logic           timeout_flag;

   uart_fifo_wr_arbiter #(
      .NUM_REQ(N), .DATA_W(W), .IDX_W(2), .TIMEOUT(TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_last_i    (req_last),
      .req_ready_o   (req_ready),
      .fifo_full_i   (fifo_full),
      .fifo_wr_en_o  (fifo_wr_en),
      .fifo_wr_data_o(fifo_wr_data),
      .grant_o       (grant),
      .busy_o        (busy),
      .timeout_flag_o(timeout_flag)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Requester sources, FIFO contents and the arbiter model
   logic [W-1:0] src_d [N][$];
   bit           src_l [N][$];
   bit           hold [N];
   bit           rand_gaps;
   bit           pop_rand;
   int           pops_left;
   logic [W-1:0] fifo_m [$];
   int           m_owner;
   int           m_rr;
   int           m_idle;
   bit           m_tflag;

   // Per-cycle observations of the DUT
   logic [N-1:0] t_grant [$];
   logic [N-1:0] t_ready [$];
   bit           t_wr [$];
   bit           t_busy [$];
   bit           t_tflag [$];
   logic [W-1:0] obs_w [$];

   function automatic int pick(input logic [N-1:0] v, input int rr);
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   task automatic load(input int r, input int len, input logic [W-1:0] base);
      for (int k = 0; k < len; k++) begin
         src_d[r].push_back(base + W'(k));
         src_l[r].push_back(k == len - 1);
      end
   endtask

   task automatic trace_clear();
      t_grant.delete(); t_ready.delete(); t_wr.delete();
      t_busy.delete(); t_tflag.delete(); obs_w.delete();
   endtask

   // Entered and left at posedge+1.
   task automatic cycle();
      logic [N-1:0] e_grant;
      logic [N-1:0] e_ready;
      bit           e_wr;
      logic [W-1:0] e_data;
      int           g;
      for (int i = 0; i < N; i++) begin
         if (src_d[i].size() > 0 && !hold[i] && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = src_d[i][0];
            req_last[i]        = src_l[i][0];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*W +: W] = W'($urandom);
            req_last[i]        = 1'($urandom);
         end
      end
      fifo_full = (fifo_m.size() >= DEPTH);
      e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_ready = fifo_full ? '0 : e_grant;
      e_wr    = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
      e_data  = (m_owner >= 0) ? req_data[m_owner*W +: W] : '0;
      #4;
      check("grant",   grant,        e_grant);
      check("busy",    busy,         m_owner >= 0);
      check("ready",   req_ready,    e_ready);
      check("wr_en",   fifo_wr_en,   e_wr);
      check("wr_data", fifo_wr_data, e_data);
      check("tflag",   timeout_flag, m_tflag);
      t_grant.push_back(grant); t_ready.push_back(req_ready); t_wr.push_back(fifo_wr_en);
      t_busy.push_back(busy);   t_tflag.push_back(timeout_flag);
      if (fifo_wr_en) obs_w.push_back(fifo_wr_data);
      @(posedge clk);
      m_tflag = 1'b0;
      if (m_owner < 0) begin
         m_owner = pick(req_valid, m_rr);
         m_idle  = 0;
      end else begin
         g = m_owner;
         if (e_wr) begin
            fifo_m.push_back(e_data);
            void'(src_d[g].pop_front());
            void'(src_l[g].pop_front());
            m_idle = 0;
            if (req_last[g]) begin
               m_rr    = (g + 1) % N;
               m_owner = -1;
            end
         end else if (!req_valid[g]) begin
`ifdef UART_ARB_GRANT_TIMEOUT_EN
            m_idle++;
            if (m_idle == TMO) begin
               m_owner = -1;
               m_rr    = (g + 1) % N;
               m_tflag = 1'b1;
            end
`endif
         end
      end
      if (pops_left > 0 && fifo_m.size() > 0) begin
         void'(fifo_m.pop_front());
         pops_left--;
      end
      if (pop_rand && fifo_m.size() > 0 && $urandom_range(0, 2) == 0) void'(fifo_m.pop_front());
      #1;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      m_owner = -1; m_rr = 0; m_idle = 0; m_tflag = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_d[i].delete(); src_l[i].delete(); hold[i] = 1'b0;
      end
      req_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int remaining;
      int loaded;
      int budget;
      logic [N-1:0] exp_g [10];
      exp_g = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0};
      reset = 1'b1; req_valid = '1; req_last = '1; req_data = '1; fifo_full = 1'b0;
      rand_gaps = 1'b0; pop_rand = 1'b0; pops_left = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy",  busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_data",  fifo_wr_data, 0);
      check("rst_tflag", timeout_flag, 0);
      apply_reset();

      // Single requester, three-byte packet
      trace_clear();
      load(0, 3, 8'h41);
      repeat (5) cycle();
      check("t1_grant_c0", t_grant[0], 4'h0);
      check("t1_grant_c1", t_grant[1], 4'h1);
      for (int k = 1; k <= 3; k++) check("t1_wr", t_wr[k], 1);
      check("t1_nbytes", obs_w.size(), 3);
      for (int k = 0; k < 3; k++) check("t1_data", obs_w[k], 8'h41 + k);
      check("t1_busy_after", t_busy[4], 0);

      // Contention from reset
      apply_reset();
      trace_clear();
      load(0, 2, 8'hA0); load(1, 2, 8'hB0); load(3, 2, 8'hD0);
      repeat (10) cycle();
      for (int k = 0; k < 10; k++) check("t2_grant_seq", t_grant[k], exp_g[k]);
      check("t2_nbytes", obs_w.size(), 6);
      check("t2_b0", obs_w[0], 8'hA0); check("t2_b1", obs_w[1], 8'hA1);
      check("t2_b2", obs_w[2], 8'hB0); check("t2_b3", obs_w[3], 8'hB1);
      check("t2_b4", obs_w[4], 8'hD0); check("t2_b5", obs_w[5], 8'hD1);
      trace_clear();
      load(0, 1, 8'h11); load(3, 1, 8'h33);
      repeat (5) cycle();
      check("t2_rr0_wins", t_grant[1], 4'h1);
      check("t2_then3",    t_grant[3], 4'h8);

      // FIFO full boundary
      fifo_m.delete();
      for (int k = 0; k < 14; k++) fifo_m.push_back(8'h00);
      trace_clear();
      load(2, 4, 8'hC0);
      repeat (4) cycle();
      check("t3_one_write", obs_w.size(), 1);
      check("t3_ready_full_c2", t_ready[2], 4'h0);
      check("t3_ready_full_c3", t_ready[3], 4'h0);
      check("t3_grant_held", t_grant[3], 4'h4);
      pops_left = 3;
      repeat (8) cycle();
      check("t3_nbytes", obs_w.size(), 4);
      for (int k = 0; k < 4; k++) check("t3_data", obs_w[k], 8'hC0 + k);
      fifo_m.delete();

      // Mid-packet stall on requester 1
      trace_clear();
      load(1, 4, 8'hB8);
      repeat (2) cycle();
      hold[1] = 1'b1;
      repeat (5) cycle();
      hold[1] = 1'b0;
      repeat (4) cycle();
      for (int k = 2; k <= 6; k++) begin
         check("t4_grant_held", t_grant[k], 4'h2);
         check("t4_no_wr", t_wr[k], 0);
      end
      check("t4_nbytes", obs_w.size(), 4);
      for (int k = 0; k < 4; k++) check("t4_data", obs_w[k], 8'hB8 + k);

      // Reset during a packet
      trace_clear();
      load(0, 4, 8'h50);
      repeat (3) cycle();
      #1 reset = 1'b1;
      #1;
      check("t5_grant", grant, 0);
      check("t5_busy",  busy, 0);
      check("t5_ready", req_ready, 0);
      check("t5_wr_en", fifo_wr_en, 0);
      apply_reset();
      trace_clear();
      load(0, 1, 8'h60); load(3, 1, 8'h63);
      repeat (5) cycle();
      check("t5_rr0_wins", t_grant[1], 4'h1);
      check("t5_first_byte", obs_w[0], 8'h60);

`ifdef UART_ARB_GRANT_TIMEOUT_EN
      // Owner goes silent; timeout hands the port to the waiting requester
      trace_clear();
      load(3, 2, 8'h70);
      cycle();
      hold[3] = 1'b1;
      load(0, 1, 8'h80);
      repeat (12) cycle();
      check("t6_grant_held", t_grant[8], 4'h8);
      check("t6_tflag_pulse", t_tflag[9], 1);
      check("t6_tflag_count", t_tflag.sum() with (int'(item)), 1);
      check("t6_req0_next", t_grant[10], 4'h1);
      hold[3] = 1'b0;
      repeat (6) cycle();
`endif

      // Randomized traffic with random gaps and FIFO drain
      rand_gaps = 1'b1;
      pop_rand  = 1'b1;
      trace_clear();
      loaded = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (src_d[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = int'($urandom_range(1, 5));
               load(i, len, W'($urandom));
               loaded += len;
            end
         end
         cycle();
      end
      budget = 0;
      remaining = 0;
      for (int i = 0; i < N; i++) remaining += src_d[i].size();
      while (remaining > 0 && budget < 2000) begin
         cycle();
         budget++;
         remaining = 0;
         for (int i = 0; i < N; i++) remaining += src_d[i].size();
      end
      check("rand_drain_left", remaining, 0);
      check("rand_bytes_written", obs_w.size(), loaded);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
